instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Sequential LEGv8 instruction encoder; inverse of the ID-stage opcode decoder.
//  Accepts one symbolic instruction per in_valid/in_ready handshake and packs it into a 32-bit word.
//  Instruction formats: R (ADD/SUB/AND/ORR), D (LDUR/STUR), CB (CBZ), B.
//  Streams encoded words over a wr_valid/wr_ready port to the instruction-memory loader at sequential byte addresses.
//  Used by the program loader and by benches to build test programs.
// PARAMETERS
//  ADDR_W     10   width of imem byte address
//  BASE_ADDR  0    byte address of first instruction (must be 4-aligned)
//  MAX_INSTR  256  capacity in words; no writes beyond BASE_ADDR+4*MAX_INSTR-4
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  in_valid      in   1       instruction fields valid
//  in_ready      out  1       encoder can accept
//  in_op         in   3       0 ADD,1 SUB,2 AND,3 ORR,4 LDUR,5 STUR,6 CBZ,7 B
//  in_rd         in   5       Rd / Rt
//  in_rn         in   5       Rn
//  in_rm         in   5       Rm (R-type only)
//  in_imm        in   26      signed immediate: DT_addr9, CB_addr19, BR_addr26 (words)
//  in_last       in   1       final instruction of program
//  wr_valid      out  1       wr_addr/wr_data valid
//  wr_ready      in   1       imem loader accepts
//  wr_addr       out  ADDR_W  byte address
//  wr_data       out  32      encoded instruction
//  count         out  ADDR_W  words written so far
//  done          out  1       sticky: last word accepted or capacity reached
//  err_range     out  1       sticky immediate range error (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: in_ready=1, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, count=0, done=0, err_range=0.
//  Reset mid-transfer drops the held word with no further write.
//  FSM: IDLE (output reg empty) -> HOLD (word pending) -> DONE.
//   - IDLE, in_valid: encode combinationally and register; wr_valid=1 the next cycle.
//     Encode latency is 1 clk.
//   - HOLD: wr_valid, wr_addr and wr_data stay stable until wr_ready.
//     in_ready = wr_ready, so a new input may load in the same cycle the held word drains (back-to-back, 1 word/clk).
//   - On write accept: count+=1 and wr_addr+=4.
//     If the drained word had in_last, or count reaches MAX_INSTR: go to DONE.
//   - DONE: in_ready=0, wr_valid=0, done=1 until reset.
//  Encoding (opcodes identical to the decoder's):
//   - R-type: {opc11, Rm, 6'b0 shamt, Rn, Rd}.
//     ADD=10001011000, SUB=11001011000, AND=10001010000, ORR=10101010000.
//   - D-type: {opc11, imm[8:0], 2'b00, Rn, Rt}. LDUR=11111000010, STUR=11111000000.
//   - CB-type: {8'b10110100, imm[18:0], Rt}.
//   - B-type: {6'b000101, imm[25:0]}.
//  Ignored fields are don't-care on input and encode as given; in_rm is used only for R-type.
//  wr_addr wraps modulo 2^ADDR_W, but the MAX_INSTR check triggers DONE first.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined:
//   - Check that in_imm sign-fits 9 bits (D-type) or 19 bits (CB-type).
//   - Out of range: input is accepted, no word is written, count is unchanged, err_range is set.
//   - If that input carried in_last, DONE is still entered.
//  IMM_RANGE_CHECK_EN undefined:
//   - The immediate is truncated to field width and written normally.
//   - err_range is tied to 0.
// TESTING
//  1. reset; ADD rd=3,rn=1,rm=2 -> wr_data=32'h8B020023, wr_addr=0, count=1 after accept.
//  2. LDUR rd=5,rn=2,imm=8, then B imm=-1 back-to-back, wr_ready=1:
//     -> 32'hF8408045 @0 then 32'h17FFFFFF @4 on consecutive clks.
//  3. CBZ rd=7,imm=4; hold wr_ready=0 for 5 clks:
//     -> wr_data stays 32'hB4000087, in_ready=0; accepted on the 6th clk.
//  4. LDUR imm=300:
//     -> with EN: err_range=1, no write, count unchanged.
//     -> without EN: wr_data imm field=9'h12C.
//  5. MAX_INSTR=4, send 5 ADDs -> 4 writes, done=1 after 4th, in_ready=0; in_last on the 2nd word -> done after 2.
//  6. Assert reset while in HOLD with wr_ready=0 -> wr_valid=0 next clk, wr_addr=BASE_ADDR, count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: packs symbolic R/D/CB/B instructions into words and streams them
// to the imem loader. Optional macro IMM_RANGE_CHECK_EN enables D/CB immediate range checking.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_INSTR = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        in_op_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rn_i,
    input  logic [4:0]        in_rm_i,
    input  logic [25:0]       in_imm_i,
    input  logic              in_last_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              done_o,
    output logic              err_range_o
);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOrr  = 3'd3;
    localparam logic [2:0] OpLdur = 3'd4;
    localparam logic [2:0] OpStur = 3'd5;
    localparam logic [2:0] OpCbz  = 3'd6;
    localparam logic [2:0] OpB    = 3'd7;

    localparam logic [ADDR_W:0]   MaxCnt  = (ADDR_W + 1)'(MAX_INSTR);
    localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrInc = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] BaseA   = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [31:0]        data_q, data_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    logic [31:0] enc;
    logic        range_err;
    logic        drain, cap_hit, accept;

    always_comb begin
        enc = '0;
        unique case (in_op_i)
            OpAdd:  enc = {11'b10001011000, in_rm_i, 6'b0, in_rn_i, in_rd_i};
            OpSub:  enc = {11'b11001011000, in_rm_i, 6'b0, in_rn_i, in_rd_i};
            OpAnd:  enc = {11'b10001010000, in_rm_i, 6'b0, in_rn_i, in_rd_i};
            OpOrr:  enc = {11'b10101010000, in_rm_i, 6'b0, in_rn_i, in_rd_i};
            OpLdur: enc = {11'b11111000010, in_imm_i[8:0], 2'b00, in_rn_i, in_rd_i};
            OpStur: enc = {11'b11111000000, in_imm_i[8:0], 2'b00, in_rn_i, in_rd_i};
            OpCbz:  enc = {8'b10110100, in_imm_i[18:0], in_rd_i};
            OpB:    enc = {6'b000101, in_imm_i};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic d_fits, cb_fits;
    // Sign-fit: all bits above the field's sign bit must equal it.
    assign d_fits  = (&in_imm_i[25:8])  | ~(|in_imm_i[25:8]);
    assign cb_fits = (&in_imm_i[25:18]) | ~(|in_imm_i[25:18]);
    always_comb begin
        range_err = 1'b0;
        if (in_op_i == OpLdur || in_op_i == OpStur) begin
            range_err = ~d_fits;
        end else if (in_op_i == OpCbz) begin
            range_err = ~cb_fits;
        end
    end
`else
    assign range_err = 1'b0;
`endif

    assign drain   = (state_q == StHold) && wr_ready_i;
    assign cap_hit = (({1'b0, count_q} + CntOne) == MaxCnt);

    // A draining word that ends the program must not let a follower slip in and be lost.
    always_comb begin
        in_ready_o = 1'b0;
        unique case (state_q)
            StIdle:  in_ready_o = 1'b1;
            StHold:  in_ready_o = wr_ready_i && !(last_q || cap_hit);
            StDone:  in_ready_o = 1'b0;
            default: in_ready_o = 1'b0;
        endcase
    end

    assign accept = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;
        if (drain) begin
            count_d = count_q + ADDR_W'(1);
            addr_d  = addr_q + AddrInc;
            state_d = (last_q || cap_hit) ? StDone : StIdle;
        end
        if (accept) begin
            if (range_err) begin
                err_d = 1'b1;
                if (in_last_i) begin
                    state_d = StDone;
                end
            end else begin
                state_d = StHold;
                data_d  = enc;
                last_d  = in_last_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= BaseA;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign wr_valid_o  = (state_q == StHold);
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;
    assign count_o     = count_q;
    assign done_o      = (state_q == StDone);
    assign err_range_o = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of single encodings plus hand-written sequences
// for back-to-back, stall, range, capacity and reset cases; writes checked via a scoreboard.
module tb_instr_encoder;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0;
    logic [25:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW-1:0] count;
    logic          done;
    logic          err_range;

    instr_encoder #(
        .ADDR_W   (AW),
        .BASE_ADDR(0),
        .MAX_INSTR(4)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_op_i    (in_op),
        .in_rd_i    (in_rd),
        .in_rn_i    (in_rn),
        .in_rm_i    (in_rm),
        .in_imm_i   (in_imm),
        .in_last_i  (in_last),
        .wr_valid_o (wr_valid),
        .wr_ready_i (wr_ready),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .count_o    (count),
        .done_o     (done),
        .err_range_o(err_range)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    vec_t          vecs[10];
    wr_t           sb[$];
    logic [AW-1:0] exp_addr;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_write(input logic [31:0] data);
        wr_t w;
        w.addr = exp_addr;
        w.data = data;
        sb.push_back(w);
        exp_addr = exp_addr + AW'(4);
    endtask

    // Scoreboard: compare each accepted write against the oldest expected one.
    always @(negedge clk) begin
        if (!reset && wr_valid && wr_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         wr_addr, wr_data);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(w.addr));
                check("wr_data", wr_data, w.data);
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_addr = '0;
        sb.delete();
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm, input logic last);
        bit ok = 1'b0;
        in_op    = op;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_imm   = imm;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 clks");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending writes expected 0", sb.size());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd0, 5'd3,  5'd1,  5'd2,  26'd0,        32'h8B020023};
        vecs[1] = '{3'd1, 5'd1,  5'd9,  5'd4,  26'd0,        32'hCB040121};
        vecs[2] = '{3'd2, 5'd31, 5'd30, 5'd29, 26'd0,        32'h8A1D03DF};
        vecs[3] = '{3'd3, 5'd0,  5'd0,  5'd31, 26'd0,        32'hAA1F0000};
        vecs[4] = '{3'd4, 5'd5,  5'd2,  5'd17, 26'd8,        32'hF8408045};
        vecs[5] = '{3'd4, 5'd1,  5'd1,  5'd0,  26'd255,      32'hF84FF021};
        vecs[6] = '{3'd5, 5'd7,  5'd3,  5'd0,  26'h3FFFF00,  32'hF8100067};
        vecs[7] = '{3'd6, 5'd7,  5'd9,  5'd0,  26'd4,        32'hB4000087};
        vecs[8] = '{3'd6, 5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  32'hB4FFFFE0};
        vecs[9] = '{3'd7, 5'd5,  5'd6,  5'd1,  26'h0123456,  32'h14123456};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_range), 32'd0);

        // Single-instruction encodings
        for (int i = 0; i < 10; i++) begin
            do_reset();
            wr_ready = 1'b1;
            expect_write(vecs[i].exp);
            send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 1'b0);
            wait_drain();
            check("vec_count", 32'(count), 32'd1);
            check("vec_next_addr", 32'(wr_addr), 32'd4);
        end

        // Back-to-back LDUR then B
        do_reset();
        wr_ready = 1'b1;
        expect_write(32'hF8408045);
        expect_write(32'h17FFFFFF);
        send(3'd4, 5'd5, 5'd2, 5'd0, 26'd8, 1'b0);
        send(3'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0);
        @(negedge clk);
        check("b2b_second_valid", 32'(wr_valid), 32'd1);
        check("b2b_second_addr", 32'(wr_addr), 32'd4);
        check("b2b_first_drained", 32'(count), 32'd1);
        wait_drain();
        check("b2b_count", 32'(count), 32'd2);

        // Stall CBZ for 5 clocks
        do_reset();
        wr_ready = 1'b0;
        send(3'd6, 5'd7, 5'd0, 5'd0, 26'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(wr_valid), 32'd1);
            check("stall_data", wr_data, 32'hB4000087);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_count", 32'(count), 32'd0);
            @(posedge clk);
        end
        #1 wr_ready = 1'b1;
        expect_write(32'hB4000087);
        wait_drain();
        check("stall_count_after", 32'(count), 32'd1);

        // Out-of-range D-type immediate
        do_reset();
        wr_ready = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        send(3'd4, 5'd5, 5'd2, 5'd0, 26'd300, 1'b0);
        repeat (3) @(negedge clk);
        check("range_err", 32'(err_range), 32'd1);
        check("range_count", 32'(count), 32'd0);
        check("range_no_valid", 32'(wr_valid), 32'd0);
        check("range_in_ready", 32'(in_ready), 32'd1);
`else
        expect_write({11'b11111000010, 9'h12C, 2'b00, 5'd2, 5'd5});
        send(3'd4, 5'd5, 5'd2, 5'd0, 26'd300, 1'b0);
        wait_drain();
        check("trunc_err", 32'(err_range), 32'd0);
        check("trunc_count", 32'(count), 32'd1);
`endif

        // Capacity limit: 5 ADDs offered, 4 written
        do_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_write(32'h8B020023);
            send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cap_in_ready", 32'(in_ready), 32'd0);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("cap_done", 32'(done), 32'd1);
        check("cap_count", 32'(count), 32'd4);
        check("cap_no_valid", 32'(wr_valid), 32'd0);
        check("cap_sb_empty", 32'(sb.size()), 32'd0);

        // in_last on the second word
        do_reset();
        wr_ready = 1'b1;
        expect_write(32'h8B020023);
        expect_write(32'hCB040121);
        send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
        send(3'd1, 5'd1, 5'd9, 5'd4, 26'd0, 1'b1);
        wait_drain();
        check("last_done", 32'(done), 32'd1);
        check("last_count", 32'(count), 32'd2);
        check("last_in_ready", 32'(in_ready), 32'd0);

        // Reset while holding a stalled word
        do_reset();
        wr_ready = 1'b0;
        send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b0);
        @(negedge clk);
        check("hold_valid", 32'(wr_valid), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rhold_valid", 32'(wr_valid), 32'd0);
        check("rhold_addr", 32'(wr_addr), 32'd0);
        check("rhold_count", 32'(count), 32'd0);
        check("rhold_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
